// File: rtl/cla_pkg.sv
// Shared sizing for the two-level carry-lookahead adder.
package cla_pkg;

  localparam int unsigned ADD_W   = 16;
  localparam int unsigned GRP_W   = 4;
  localparam int unsigned NUM_GRP = ADD_W / GRP_W;

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: flattened internal carries plus group propagate/generate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             pg,
  output logic             gg
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] c;

  // Bit generate/propagate, two-level carry equations (no ripple), sum and group terms.
  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    s  = p ^ c;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder with registered sum and carry-out.
module cla_adder_16
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             carry_in,
  output logic [ADD_W-1:0] sum,
  output logic             carry_out
);

  logic [NUM_GRP-1:0] grp_p;
  logic [NUM_GRP-1:0] grp_g;
  logic [NUM_GRP:0]   grp_c;   // grp_c[k] is the carry into group k; grp_c[NUM_GRP] is C16
  logic [ADD_W-1:0]   sum_d;
  logic [ADD_W-1:0]   sum_q;
  logic               carry_q;

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    cla_group4 u_grp (
      .a   (a[gi*GRP_W +: GRP_W]),
      .b   (b[gi*GRP_W +: GRP_W]),
      .cin (grp_c[gi]),
      .s   (sum_d[gi*GRP_W +: GRP_W]),
      .pg  (grp_p[gi]),
      .gg  (grp_g[gi])
    );
  end

  // Level-2 lookahead: every group carry is a flat function of PG/GG and carry_in.
  always_comb begin
    grp_c[0] = carry_in;
    grp_c[1] = grp_g[0] | (grp_p[0] & carry_in);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carry_in);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & carry_in);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & carry_in);
  end

  // Output register; reset clears asynchronously and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= grp_c[NUM_GRP];
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16: directed table, reset corners, random vs. arithmetic model.
module tb_cla_adder_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic [15:0] sum;
  logic        carry_out;

  int n_total;
  int n_pass;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        co;
    string       name;
  } vec_t;

  vec_t vecs[10];

  cla_adder_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [16:0] exp);
    n_total++;
    if ({carry_out, sum} === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got co=%b sum=%h, want co=%b sum=%h",
               name, carry_out, sum, exp[16], exp[15:0]);
    end
  endtask

  // Drive operands mid-cycle, then sample just after the capturing edge.
  task automatic step(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    a        = ta;
    b        = tb_;
    carry_in = tc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{16'd10,   16'd22,   1'b0, 16'd32,   1'b0, "add_10_22"};
    vecs[1] = '{16'd10,   16'd22,   1'b1, 16'd33,   1'b0, "add_10_22_c"};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "prop_ffff_cin"};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ffff_plus_1"};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb_overflow"};
    vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "cross_groups"};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "max_all"};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "cross_grp1"};
    vecs[8] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, "prop_aaaa"};
    vecs[9] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "no_carry"};

    // Reset asserted before any clock edge: outputs clear immediately.
    rst_n    = 1'b1;
    a        = 16'd0;
    b        = 16'd0;
    carry_in = 1'b0;
    #1 rst_n = 1'b0;
    a        = 16'h1234;
    b        = 16'h1111;
    #1 check("reset_async", 17'd0);
    @(posedge clk);
    #1 check("reset_hold", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hold a=10, b=22 for 150 ns; result must stay at 32.
    step(16'd10, 16'd22, 1'b0);
    check("hold_first", 17'd32);
    #150;
    check("hold_150ns", 17'd32);

    // Alternate carry_in every 150 ns: sum toggles 32/33.
    for (int i = 0; i < 4; i++) begin
      step(16'd10, 16'd22, ~i[0]);
      #150;
      check(i[0] ? "toggle_cin0" : "toggle_cin1", i[0] ? 17'd32 : 17'd33);
    end

    // Directed table, one vector per cycle.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cin);
      check(vecs[i].name, {vecs[i].co, vecs[i].sum});
    end

    // Mid-stream reset: load a nonzero result, change operands, pulse reset between edges.
    step(16'h0FFF, 16'h0FFF, 1'b1);
    check("pre_reset", 17'h01FFF);
    @(negedge clk);
    a        = 16'd10;
    b        = 16'd22;
    carry_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_midstream", 17'd0);
    #1 rst_n = 1'b1;
    #1 check("reset_released", 17'd0);
    @(posedge clk);
    #1 check("after_reset_edge", 17'd32);

    // Random operands, one set per cycle, plus forced all-propagate patterns.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = (i % 16 == 0) ? ~ra : 16'($urandom);
      rc = 1'($urandom);
      step(ra, rb, rc);
      check("random", model(ra, rb, rc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cla_adder_16.md
Name: cla_adder_16

Overview:
- 16-bit two-level carry-lookahead adder: sum = a + b + carry_in, with carry-out.
- Combinational CLA core feeding an output register; one-cycle latency.
- Used as the fast-add datapath element wherever a registered 16-bit add with carry chaining is needed.

Parameters:
- none. Width is fixed at 16; group size is 4, taken from the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- a  input  16  addend A, unsigned
- b  input  16  addend B, unsigned
- carry_in  input  1  carry into bit 0
- sum  output  16  registered (a + b + carry_in) mod 2^16
- carry_out  output  1  registered carry out of bit 15

Behaviour:
- Reset:
  - rst_n low immediately forces sum = 16'h0000 and carry_out = 0, independent of clk.
  - Outputs hold these values while rst_n stays low.
  - First capture happens on the first rising clk edge after rst_n deasserts.
- Bit level:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - s[i] = p[i] ^ c[i]
  - c[0] = carry_in
- Level 1: four 4-bit groups (bits 3:0, 7:4, 11:8, 15:12).
  - Each group computes its internal carries as flattened lookahead equations from g, p and the group carry-in. No ripple chain.
  - Each group also produces group propagate PG = p3&p2&p1&p0 and group generate GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Level 2: a lookahead unit produces group carries C4, C8, C12 and C16 from PG/GG and carry_in.
  - Example: C8 = GG1 | PG1·GG0 | PG1·PG0·cin.
  - carry_out = C16.
- Timing:
  - The sum and carry are purely combinational from a, b and carry_in.
  - Both are captured into the sum/carry_out registers on each rising clk edge while rst_n is high.
  - Latency is exactly 1 cycle. A new operand set is accepted every cycle, with no handshake.
- Arithmetic:
  - Result is unsigned modulo 2^16; overflow appears only as carry_out = 1.
  - {carry_out, sum} == a + b + carry_in as a 17-bit value for every input combination.
- Boundary conditions:
  - All-propagate (a ^ b = 16'hFFFF, carry_in = 1): the carry must traverse both lookahead levels and give sum = 0, carry_out = 1.
  - Operands changing every cycle: each registered result corresponds to the operands sampled on the preceding edge only.
  - rst_n asserted mid-stream: the in-flight result is discarded and outputs clear asynchronously.
  - X-free: no latches; every combinational output is fully assigned.

Decomposition:
- Shared package cla_pkg holds:
  - ADD_W = 16
  - GRP_W = 4
  - NUM_GRP = ADD_W / GRP_W
- One sub-module, cla_group4:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], pg, gg.
  - Instantiated four times.
- The level-2 lookahead equations and the output register live in cla_adder_16.

Test Plan:
- a=10, b=22, carry_in=0 -> one cycle later sum=32, carry_out=0. Hold 150 ns; the value stays stable.
- a=10, b=22, carry_in=1 -> sum=33, carry_out=0. Alternate carry_in 0/1 every 150 ns: sum toggles 32/33.
- a=16'hFFFF, b=16'h0000, carry_in=1 -> sum=16'h0000, carry_out=1 (full propagate path). Repeat with a=16'hFFFF, b=16'h0001, carry_in=0 for the same result.
- a=16'h8000, b=16'h8000, carry_in=0 -> sum=0, carry_out=1. Also a=16'h0FFF, b=16'h0001 -> sum=16'h1000, carry_out=0 (carry crosses group boundaries).
- Reset: drive a=10, b=22, then pulse rst_n low between clock edges -> sum=0 and carry_out=0 immediately. The first edge after release gives 32.
- 10k random {a, b, carry_in} vectors at one per cycle -> {carry_out, sum} equals the 17-bit a+b+cin of the previous cycle, with zero mismatches.
